// File: rtl/number_scan_if.sv
// Handshake and classifier bus between a requester and number_scan_ctrl.
// The NUMBER_SCAN_LASTPRIME_EN macro adds the last_prime/last_prime_vld signals.
interface number_scan_if #(
  parameter int unsigned CW = 5
);
  localparam int unsigned AW = 4;

  logic          start;
  logic          abort;
  logic [AW-1:0] lo;
  logic [AW-1:0] hi;
  logic [AW-1:0] a;
  logic          p;
  logic          d;
  logic          busy;
  logic          done;
  logic [CW-1:0] prime_cnt;
  logic [CW-1:0] div3_cnt;
`ifdef NUMBER_SCAN_LASTPRIME_EN
  logic [AW-1:0] last_prime;
  logic          last_prime_vld;

  modport master (
    output start, abort, lo, hi, p, d,
    input  a, busy, done, prime_cnt, div3_cnt, last_prime, last_prime_vld
  );

  modport slave (
    input  start, abort, lo, hi, p, d,
    output a, busy, done, prime_cnt, div3_cnt, last_prime, last_prime_vld
  );
`else
  modport master (
    output start, abort, lo, hi, p, d,
    input  a, busy, done, prime_cnt, div3_cnt
  );

  modport slave (
    input  start, abort, lo, hi, p, d,
    output a, busy, done, prime_cnt, div3_cnt
  );
`endif
endinterface

// File: rtl/number_scan_ctrl.sv
// Walks a wrapping 4-bit range lo..hi through an external classifier, counting primes and multiples of 3.
// Optional last-prime tracking is enabled with NUMBER_SCAN_LASTPRIME_EN.
module number_scan_ctrl #(
  parameter int unsigned CW = 5
) (
  input  logic          clk,
  input  logic          reset,
  number_scan_if.slave  bus
);
  localparam int unsigned AW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] a_q, a_d;
  logic [AW-1:0] hi_q, hi_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [CW-1:0] pcnt_q, pcnt_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
`ifdef NUMBER_SCAN_LASTPRIME_EN
  logic [AW-1:0] lp_q, lp_d;
  logic          lpv_q, lpv_d;
`endif

  // State and datapath registers; reset overrides everything including a live scan.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      hi_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pcnt_q  <= '0;
      dcnt_q  <= '0;
`ifdef NUMBER_SCAN_LASTPRIME_EN
      lp_q    <= '0;
      lpv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pcnt_q  <= pcnt_d;
      dcnt_q  <= dcnt_d;
`ifdef NUMBER_SCAN_LASTPRIME_EN
      lp_q    <= lp_d;
      lpv_q   <= lpv_d;
`endif
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    hi_d    = hi_q;
    pcnt_d  = pcnt_q;
    dcnt_d  = dcnt_q;
`ifdef NUMBER_SCAN_LASTPRIME_EN
    lp_d    = lp_q;
    lpv_d   = lpv_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          hi_d    = bus.hi;
          a_d     = bus.lo;
          pcnt_d  = '0;
          dcnt_d  = '0;
`ifdef NUMBER_SCAN_LASTPRIME_EN
          lp_d    = '0;
          lpv_d   = 1'b0;
`endif
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          pcnt_d = pcnt_q + CW'(bus.p);
          dcnt_d = dcnt_q + CW'(bus.d);
`ifdef NUMBER_SCAN_LASTPRIME_EN
          if (bus.p) begin
            lp_d  = a_q;
            lpv_d = 1'b1;
          end
`endif
          if (a_q == hi_q) begin
            state_d = DONE;
          end else begin
            a_d = a_q + AW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SCAN);
    done_d = (state_d == DONE);
  end

  assign bus.a         = a_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.prime_cnt = pcnt_q;
  assign bus.div3_cnt  = dcnt_q;
`ifdef NUMBER_SCAN_LASTPRIME_EN
  assign bus.last_prime     = lp_q;
  assign bus.last_prime_vld = lpv_q;
`endif
endmodule

// File: tb/tb_number_scan_ctrl.sv
// Randomized bench for number_scan_ctrl against a list-based scan model.
// Checks last_prime outputs when NUMBER_SCAN_LASTPRIME_EN is defined.
module tb_number_scan_ctrl;
  localparam int unsigned CW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  number_scan_if #(.CW(CW)) bus();
  number_scan_ctrl #(.CW(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Classifier stand-in: flag tables indexed by the operand.
  logic [15:0] ptab, dtab;
  assign bus.p = ptab[bus.a];
  assign bus.d = dtab[bus.a];

  int n_cmp = 0;
  int n_err = 0;
  int exp_p, exp_d, exp_lp, exp_lpv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] prime_table();
    logic [15:0] t = '0;
    for (int v = 2; v < 16; v++) begin
      bit pr = 1'b1;
      for (int k = 2; k < v; k++) if (v % k == 0) pr = 1'b0;
      t[v] = pr;
    end
    return t;
  endfunction

  function automatic logic [15:0] div3_table();
    logic [15:0] t = '0;
    for (int v = 0; v < 16; v++) t[v] = (v % 3 == 0);
    return t;
  endfunction

  task automatic check_results(input string tag);
    check({tag, "_pcnt"}, 32'(bus.prime_cnt), 32'(exp_p));
    check({tag, "_dcnt"}, 32'(bus.div3_cnt), 32'(exp_d));
`ifdef NUMBER_SCAN_LASTPRIME_EN
    check({tag, "_lp"}, 32'(bus.last_prime), 32'(exp_lp));
    check({tag, "_lpv"}, 32'(bus.last_prime_vld), 32'(exp_lpv));
`endif
  endtask

  // mode 0: run to completion, 1: abort at scan index 'at', 2: reset at scan index 'at'.
  task automatic scan(input logic [3:0] lo, input logic [3:0] hi, input int mode,
                      input int at, input bit noise);
    int vals[$];
    logic [3:0] v;
    int stop;
    v = lo;
    forever begin
      vals.push_back(int'(v));
      if (v == hi) break;
      v = v + 4'd1;
    end
    stop = (at >= vals.size()) ? vals.size() - 1 : at;

    @(negedge clk);
    bus.lo = lo;
    bus.hi = hi;
    bus.start = 1'b1;
    bus.abort = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    exp_p = 0; exp_d = 0; exp_lp = 0; exp_lpv = 0;

    for (int i = 0; i < vals.size(); i++) begin
      check("scan_busy", 32'(bus.busy), 32'd1);
      check("scan_a", 32'(bus.a), 32'(vals[i]));
      check("scan_done", 32'(bus.done), 32'd0);
      if (mode != 0 && i == stop) begin
        if (mode == 1) bus.abort = 1'b1;
        else reset = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        reset = 1'b0;
        if (mode == 2) begin
          exp_p = 0; exp_d = 0; exp_lp = 0; exp_lpv = 0;
          check("rst_a", 32'(bus.a), 32'd0);
        end
        check("stop_busy", 32'(bus.busy), 32'd0);
        check("stop_done", 32'(bus.done), 32'd0);
        check_results("stop");
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_done", 32'(bus.done), 32'd0);
        check_results("idle");
        return;
      end
      exp_p += int'(ptab[vals[i]]);
      exp_d += int'(dtab[vals[i]]);
      if (ptab[vals[i]]) begin
        exp_lp = vals[i];
        exp_lpv = 1;
      end
      if (noise) begin
        bus.start = ($urandom_range(0, 2) == 0);
        bus.lo = 4'($urandom);
        bus.hi = 4'($urandom);
      end
      @(negedge clk);
      bus.start = 1'b0;
    end

    check("done_pulse", 32'(bus.done), 32'd1);
    check("done_busy", 32'(bus.busy), 32'd0);
    check_results("done");
    if (noise) begin
      bus.start = 1'($urandom_range(0, 1));
      bus.abort = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("after_done", 32'(bus.done), 32'd0);
    check("after_busy", 32'(bus.busy), 32'd0);
    check("after_a", 32'(bus.a), 32'(vals[vals.size()-1]));
    check_results("hold");
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.lo = '0;
    bus.hi = '0;
    ptab = prime_table();
    dtab = div3_table();
    exp_p = 0; exp_d = 0; exp_lp = 0; exp_lpv = 0;
    repeat (3) @(negedge clk);
    check("rst_a", 32'(bus.a), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check_results("rst");
    reset = 1'b0;
    @(negedge clk);
    check("rst_nodone", 32'(bus.done), 32'd0);

    // Directed cases with the real classifier.
    scan(4'd0,  4'd15, 0, 0, 1'b0);
    check("full_p6", 32'(exp_p), 32'd6);
    scan(4'd7,  4'd7,  0, 0, 1'b0);
    scan(4'd14, 4'd2,  0, 0, 1'b0);
    scan(4'd0,  4'd15, 1, 3, 1'b0);
    scan(4'd2,  4'd13, 2, 4, 1'b0);
    scan(4'd2,  4'd13, 0, 0, 1'b0);
    scan(4'd9,  4'd12, 0, 0, 1'b1);
    scan(4'd5,  4'd4,  0, 0, 1'b1);

    // Random ranges, flag tables, aborts and resets.
    for (int n = 0; n < 60; n++) begin
      int r;
      ptab = 16'($urandom);
      dtab = 16'($urandom);
      r = $urandom_range(0, 9);
      scan(4'($urandom), 4'($urandom), (r < 6) ? 0 : ((r < 9) ? 1 : 2),
           $urandom_range(0, 15), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
